// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the tick generator.
//   TG_DIV_W        default width of the period/counter registers
//   TG_DEFAULT_DIV  default period loaded into every channel at reset
//   ch_idx_w()      channel-index width, $clog2(n) with a floor of 1
package tick_gen_pkg;

  localparam int TG_DIV_W       = 16;
  localparam int TG_DEFAULT_DIV = 4;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen_channel.sv
// One clock-enable channel: a wrapping counter with a committed (active) period
// and a shadow period that is taken over at the wrap or on sync.
// Ports:
//   clk, rst  master clock, async active-high reset
//   en        run enable; 0 freezes the counter and holds sq
//   sync      restart at cnt=0 and commit the shadow period
//   wr        write strobe for this channel
//   wr_div    period written into the shadow register
//   tick      one-cycle pulse per period
//   sq        square enable, high for ceil(D/2) cycles per period
//   pend      shadow period written but not yet committed
module tick_gen_channel
  import tick_gen_pkg::*;
#(
  parameter int DIV_W       = TG_DIV_W,
  parameter int DEFAULT_DIV = TG_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             tick,
  output logic             sq,
  output logic             pend
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] active_q;
  logic [DIV_W-1:0] shadow_q;
  logic             pend_q;
  logic             tick_q;
  logic             sq_q;

  logic [DIV_W-1:0] next_div;
  logic [DIV_W:0]   half;
  logic             fast;
  logic             at_end;
  logic             wrap;
  logic             sq_next;

  // A write in the same cycle as a commit is the value that gets committed.
  assign next_div = wr ? wr_div : shadow_q;

  // D=0 and D=1 both wrap every cycle; the D-1 compare is only reached for D>=2.
  assign fast   = (active_q <= DIV_W'(1));
  assign at_end = fast || (cnt_q == (active_q - DIV_W'(1)));
  assign wrap   = en && at_end;

  assign half    = ({1'b0, active_q} + (DIV_W + 1)'(1)) >> 1;
  assign sq_next = fast || ({1'b0, cnt_q} < half);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= DIV_W'(DEFAULT_DIV);
      shadow_q <= DIV_W'(DEFAULT_DIV);
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      sq_q     <= 1'b0;
    end else begin
      shadow_q <= next_div;
      if (en) begin
        sq_q <= sq_next;
      end
      if (sync) begin
        cnt_q    <= '0;
        active_q <= next_div;
        pend_q   <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        tick_q <= wrap;
        if (wrap) begin
          cnt_q    <= '0;
          active_q <= next_div;
          pend_q   <= 1'b0;
        end else begin
          if (en) begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
          if (wr) begin
            pend_q <= 1'b1;
          end
        end
      end
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;
  assign pend = pend_q;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel clock-enable generator. Each channel produces a tick pulse and a
// 50%-duty square enable in the clk domain with a runtime-programmable period.
// Ports:
//   clk, rst  master clock, async active-high reset
//   en        global run; 0 freezes all channel counters
//   sync      restart all channels phase-aligned and commit pending periods
//   wr_en     period write strobe
//   wr_ch     channel index for the write; indices >= NCH are ignored
//   wr_div    new period, in clk cycles
//   tick      per-channel one-cycle pulse per period
//   sq        per-channel square enable
//   pend      per-channel "written period not yet committed"
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int DIV_W       = TG_DIV_W,
  parameter int DEFAULT_DIV = TG_DEFAULT_DIV
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     sync,
  input  logic                     wr_en,
  input  logic [ch_idx_w(NCH)-1:0] wr_ch,
  input  logic [DIV_W-1:0]         wr_div,
  output logic [NCH-1:0]           tick,
  output logic [NCH-1:0]           sq,
  output logic [NCH-1:0]           pend
);

  localparam int CH_W = ch_idx_w(NCH);

  logic [NCH-1:0] wr_sel;

  // Out-of-range indices match no channel, so such writes fall away.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_en && (wr_ch == CH_W'(i))) begin
        wr_sel[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tick_gen_channel #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .sync  (sync),
      .wr    (wr_sel[g]),
      .wr_div(wr_div),
      .tick  (tick[g]),
      .sq    (sq[g]),
      .pend  (pend[g])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
module tb_tick_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [15:0] wr_div = '0;
  logic [3:0]  tick, sq, pend;

  // Three-channel instance so that wr_ch = NCH is representable.
  logic        wr_en3 = 1'b0;
  logic [1:0]  wr_ch3 = '0;
  logic [15:0] wr_div3 = '0;
  logic [2:0]  tick3, sq3, pend3;

  int total = 0;
  int bad = 0;

  tick_gen #(.NCH(4), .DIV_W(16), .DEFAULT_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_div(wr_div), .tick(tick), .sq(sq), .pend(pend)
  );

  tick_gen #(.NCH(3), .DIV_W(16), .DEFAULT_DIV(4)) dut3 (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .wr_en(wr_en3), .wr_ch(wr_ch3),
    .wr_div(wr_div3), .tick(tick3), .sq(sq3), .pend(pend3)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_first;
    bit          en;
    bit          sync;
    bit          wr_en;
    logic [1:0]  wr_ch;
    logic [15:0] wr_div;
    logic [3:0]  tick;
    logic [3:0]  sq;
    logic [3:0]  pend;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit e, input bit s, input bit w, input logic [1:0] c,
                     input logic [15:0] d, input logic [3:0] t, input logic [3:0] q,
                     input logic [3:0] p);
    vec_t v;
    v.rst_first = r; v.en = e; v.sync = s; v.wr_en = w; v.wr_ch = c; v.wr_div = d;
    v.tick = t; v.sq = q; v.pend = p;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    wr_en3 = 1'b0; wr_ch3 = '0; wr_div3 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Default D=4: ticks at 4,8,12; sq 1,1,0,0.
    for (int k = 1; k <= 12; k++) begin
      add(k == 1, 1, 0, 0, 2'd0, 16'd0, (k % 4 == 0) ? 4'hF : 4'h0,
          ((k % 4 == 1) || (k % 4 == 2)) ? 4'hF : 4'h0, 4'h0);
    end
    // ch1 D=5 written at cycle 2: ticks 4, 9, 14; sq 3 high / 2 low.
    add(1, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'hF, 4'h0);
    add(0, 1, 0, 1, 2'd1, 16'd5, 4'h0, 4'hF, 4'h2);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'h0, 4'h2);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'hF, 4'h0, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'hF, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'hF, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'h2, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'hD, 4'h0, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h2, 4'hD, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'hF, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'h2, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'hD, 4'h2, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'hD, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h2, 4'hD, 4'h0);
    // ch0 D=1 via sync, en pause of 3 cycles, then D=0 written in a wrap cycle.
    add(1, 0, 1, 1, 2'd0, 16'd1, 4'h0, 4'h0, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h1, 4'hF, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h1, 4'hF, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h1, 4'h1, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'hF, 4'h1, 4'h0);
    add(0, 0, 0, 0, 2'd0, 16'd0, 4'h0, 4'h1, 4'h0);
    add(0, 0, 0, 0, 2'd0, 16'd0, 4'h0, 4'h1, 4'h0);
    add(0, 0, 0, 0, 2'd0, 16'd0, 4'h0, 4'h1, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h1, 4'hF, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h1, 4'hF, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h1, 4'h1, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'hF, 4'h1, 4'h0);
    add(0, 1, 0, 1, 2'd0, 16'd0, 4'h1, 4'hF, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h1, 4'hF, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h1, 4'h1, 4'h0);
    // ch0 D=3, ch1 D=7 drifting; sync with a ch2 D=6 write: ticks +3, +7, +6 (ch3 +4).
    add(1, 0, 0, 1, 2'd0, 16'd3, 4'h0, 4'h0, 4'h1);
    add(0, 0, 0, 1, 2'd1, 16'd7, 4'h0, 4'h0, 4'h3);
    add(0, 0, 1, 0, 2'd0, 16'd0, 4'h0, 4'h0, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'hF, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'hF, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h1, 4'h2, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'hC, 4'h3, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'hD, 4'h0);
    add(0, 0, 1, 1, 2'd2, 16'd6, 4'h0, 4'hD, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'hF, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'hF, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h1, 4'h6, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h8, 4'h3, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'h9, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h5, 4'h8, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h2, 4'h5, 4'h0);
    // Write ch0 D=2 in its wrap cycle: effective in the very next period.
    add(1, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'hF, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'hF, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'h0, 4'h0);
    add(0, 1, 0, 1, 2'd0, 16'd2, 4'hF, 4'h0, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'hF, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h1, 4'hE, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'h0, 4'h1, 4'h0);
    add(0, 1, 0, 0, 2'd0, 16'd0, 4'hF, 4'h0, 4'h0);

    // Reset state.
    do_reset();
    check("reset tick", {28'd0, tick}, 32'd0);
    check("reset sq", {28'd0, sq}, 32'd0);
    check("reset pend", {28'd0, pend}, 32'd0);
    check("reset pend3", {29'd0, pend3}, 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      en = vecs[i].en; sync = vecs[i].sync; wr_en = vecs[i].wr_en;
      wr_ch = vecs[i].wr_ch; wr_div = vecs[i].wr_div;
      cycle();
      check($sformatf("vec%0d tick", i), {28'd0, tick}, {28'd0, vecs[i].tick});
      check($sformatf("vec%0d sq", i), {28'd0, sq}, {28'd0, vecs[i].sq});
      check($sformatf("vec%0d pend", i), {28'd0, pend}, {28'd0, vecs[i].pend});
    end

    // Out-of-range write (wr_ch = NCH = 3) on the three-channel instance.
    do_reset();
    en = 1'b1;
    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_div3 = 16'd2;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      wr_en3 = 1'b0;
      check($sformatf("oor pend3 c%0d", k), {29'd0, pend3}, 32'd0);
      check($sformatf("oor tick3 c%0d", k), {29'd0, tick3}, (k % 4 == 0) ? 32'h7 : 32'h0);
    end

    // Async reset mid-period with D=1000 on ch0 and a pending write on ch1.
    do_reset();
    sync = 1'b1; wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd1000;
    cycle();
    sync = 1'b0; wr_en = 1'b0; en = 1'b1;
    repeat (5) cycle();
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd9;
    cycle();
    wr_en = 1'b0;
    check("pre-rst pend", {28'd0, pend}, 32'h2);
    check("pre-rst sq0", {31'd0, sq[0]}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async rst tick", {28'd0, tick}, 32'd0);
    check("async rst sq", {28'd0, sq}, 32'd0);
    check("async rst pend", {28'd0, pend}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle();
    check("post-rst tick c3", {28'd0, tick}, 32'd0);
    cycle();
    check("post-rst tick c4", {28'd0, tick}, 32'hF);
    check("post-rst sq c4", {28'd0, sq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
